// File: rtl/i2s_pkg.sv
// Shared I2S frame constants, used by the sample FIFO and the i2s_tx serializer.
//   FRAME_W    : width of one stereo frame handed to the serializer
//   SLOT_W     : width of one channel slot inside the frame
//   LEFT_MSB   : bit position of the left slot MSB ([63:32] = left)
//   RIGHT_MSB  : bit position of the right slot MSB ([31:0] = right)
//   UNDERRUN_W : width of the saturating underrun counter
package i2s_pkg;

    localparam int unsigned FRAME_W    = 64;
    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned LEFT_MSB   = 63;
    localparam int unsigned RIGHT_MSB  = 31;
    localparam int unsigned UNDERRUN_W = 16;

    typedef logic [FRAME_W-1:0]    frame_t;
    typedef logic [SLOT_W-1:0]     slot_t;
    typedef logic [UNDERRUN_W-1:0] underrun_t;

    // Left-justify a sign-extended sample into a slot; the sign bit lands on the slot MSB.
    function automatic slot_t left_justify(input slot_t ext, input int unsigned pad);
        return ext << pad;
    endfunction

endpackage

// File: rtl/i2s_fifo_mem.sv
// Frame storage for the sample FIFO: DEPTH x FRAME_W, one synchronous write port,
// asynchronous read at the supplied read address. No control logic lives here.
//   clk_i   : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : frame to store
//   raddr_i : read address
//   rdata_o : frame at raddr_i (combinational)
module i2s_fifo_mem
    import i2s_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  frame_t           wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output frame_t           rdata_o
);

    frame_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/i2s_sample_fifo.sv
// Upstream feeder for i2s_tx. Buffers signed stereo samples from the mixer, left-justifies
// each channel into a 32-bit slot and commits one 64-bit frame per serializer frame event.
//   sclk, aclr_n         : bit clock, asynchronous active-low reset
//   in_valid/in_ready    : mixer handshake; in_left/in_right are the signed samples
//   tx_ready             : serializer ready; its rising edge is the frame event
//   sample, sample_ready : committed frame and "a frame will be committed at next event"
//   level                : FIFO occupancy 0..DEPTH
//   underrun_count       : saturating count of frame events with nothing queued
//   clear_underrun       : synchronous clear, wins over a same-cycle increment
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                       sclk,
    input  logic                       aclr_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] in_left,
    input  logic signed [SAMPLE_W-1:0] in_right,
    input  logic                       tx_ready,
    output logic [FRAME_W-1:0]         sample,
    output logic                       sample_ready,
    output logic [LVL_W-1:0]           level,
    output logic [UNDERRUN_W-1:0]      underrun_count,
    input  logic                       clear_underrun
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned PAD   = SLOT_W - SAMPLE_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    frame_t           sample_q, sample_d;
    logic             sample_ready_q, sample_ready_d;
    logic             tx_ready_q;
    underrun_t        underrun_q, underrun_d;

    logic   push, evt, pop;
    slot_t  left_slot, right_slot;
    frame_t wr_frame, head;

    // Sign-extend first so SAMPLE_W == SLOT_W needs no zero-width padding.
    assign left_slot  = left_justify(SLOT_W'(in_left), PAD);
    assign right_slot = left_justify(SLOT_W'(in_right), PAD);

    always_comb begin
        wr_frame                           = '0;
        wr_frame[LEFT_MSB -: SLOT_W]       = left_slot;
        wr_frame[RIGHT_MSB -: SLOT_W]      = right_slot;
    end

    i2s_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (sclk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_frame),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // No bypass: a full FIFO refuses pushes even when a pop happens the same cycle.
    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign evt      = tx_ready && !tx_ready_q;
    // sample_ready_q tracks level_q != 0, so a pop can never hit an empty FIFO.
    assign pop      = evt && sample_ready_q;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        sample_d       = sample_q;
        underrun_d     = underrun_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            sample_d = head;
        end else if (evt) begin
            sample_d = '0;
        end

        if (clear_underrun) begin
            underrun_d = '0;
        end else if (evt && !sample_ready_q && (underrun_q != '1)) begin
            underrun_d = underrun_q + UNDERRUN_W'(1);
        end

        level_d        = level_q + LVL_W'(push) - LVL_W'(pop);
        sample_ready_d = (level_d != '0);
    end

    always_ff @(posedge sclk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            sample_q       <= '0;
            sample_ready_q <= 1'b0;
            // High so the serializer's ready held through reset is not seen as an edge.
            tx_ready_q     <= 1'b1;
            underrun_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            sample_q       <= sample_d;
            sample_ready_q <= sample_ready_d;
            tx_ready_q     <= tx_ready;
            underrun_q     <= underrun_d;
        end
    end

    assign sample         = sample_q;
    assign sample_ready   = sample_ready_q;
    assign level          = level_q;
    assign underrun_count = underrun_q;

endmodule
